// File: rtl/m8c_issp_pkg.sv
// Shared ISSP definitions: vector width, host register-select encodings and the
// vector type used by both the vector queue and the shift engine.
package m8c_issp_pkg;

  localparam int ISSP_VEC_SIZE = 22;

  typedef enum logic [1:0] {
    VECQ_SEL_LO   = 2'd0,
    VECQ_SEL_MED  = 2'd1,
    VECQ_SEL_HI   = 2'd2,
    VECQ_SEL_PUSH = 2'd3
  } vecq_sel_e;

  typedef logic [ISSP_VEC_SIZE-1:0] issp_vec_t;

endpackage

// File: rtl/m8c_issp_vecq_if.sv
// Host-write / engine-read bundle of the ISSP vector queue.
// slave = the queue itself, master = the host/engine side driving it.
interface m8c_issp_vecq_if #(
  parameter int DEPTH    = 8,
  parameter int VEC_SIZE = 22
);
  logic                       wr_en;
  logic [1:0]                 wr_sel;
  logic [7:0]                 wr_data;
  logic                       flush;
  logic                       vec_valid;
  logic [VEC_SIZE-1:0]        vec_data;
  logic                       vec_ready;
  logic [$clog2(DEPTH):0]     level;
  logic                       full;
  logic                       empty;
  logic                       overflow;

  modport slave (
    input  wr_en, wr_sel, wr_data, flush, vec_ready,
    output vec_valid, vec_data, level, full, empty, overflow
  );

  modport master (
    output wr_en, wr_sel, wr_data, flush, vec_ready,
    input  vec_valid, vec_data, level, full, empty, overflow
  );
endinterface

// File: rtl/m8c_issp_vec_fifo.sv
// Generic synchronous first-word-fall-through FIFO with flush. Occupancy (level)
// is the single source of full/empty; dout reads 0 while empty.
module m8c_issp_vec_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 22
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_push;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/m8c_issp_vecq.sv
// ISSP vector queue: byte-lane staging register feeding a FWFT vector FIFO.
// Macro M8C_ISSP_VECQ_STICKY_OVF_EN makes overflow sticky instead of a pulse.
module m8c_issp_vecq
  import m8c_issp_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int VEC_SIZE = ISSP_VEC_SIZE
) (
  input  logic            osc,
  input  logic            rst_n,
  m8c_issp_vecq_if.slave  vq
);
  logic [VEC_SIZE-1:0] staging;
  logic                push_req;
  logic                pop_fire;
  logic                drop;
  logic                overflow_q;

  assign push_req = vq.wr_en && (vq.wr_sel == VECQ_SEL_PUSH) && !vq.flush;
  assign pop_fire = vq.vec_valid && vq.vec_ready;
  assign drop     = push_req && vq.full && !pop_fire;

  assign vq.vec_valid = !vq.empty;
  assign vq.overflow  = overflow_q;

  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      staging <= '0;
    end else if (vq.flush) begin
      staging <= '0;
    end else if (vq.wr_en) begin
      case (vecq_sel_e'(vq.wr_sel))
        VECQ_SEL_LO:  staging[7:0]            <= vq.wr_data;
        VECQ_SEL_MED: staging[15:8]           <= vq.wr_data;
        VECQ_SEL_HI:  staging[VEC_SIZE-1:16]  <= vq.wr_data[VEC_SIZE-17:0];
        default:      staging                 <= staging;
      endcase
    end
  end

  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (vq.flush) begin
      overflow_q <= 1'b0;
    end else begin
`ifdef M8C_ISSP_VECQ_STICKY_OVF_EN
      overflow_q <= overflow_q | drop;
`else
      overflow_q <= drop;
`endif
    end
  end

  m8c_issp_vec_fifo #(
    .DEPTH (DEPTH),
    .W     (VEC_SIZE)
  ) u_fifo (
    .clk   (osc),
    .rst_n (rst_n),
    .flush (vq.flush),
    .push  (push_req),
    .din   (staging),
    .pop   (vq.vec_ready),
    .dout  (vq.vec_data),
    .level (vq.level),
    .full  (vq.full),
    .empty (vq.empty)
  );

endmodule

// File: tb/tb_m8c_issp_vecq.sv
// Directed + randomized bench for m8c_issp_vecq against a queue-based reference
// model (honours M8C_ISSP_VECQ_STICKY_OVF_EN for the overflow expectation).
module tb_m8c_issp_vecq;
  localparam int DEPTH = 8;
  localparam int VS    = 22;

  logic osc   = 1'b0;
  logic rst_n = 1'b0;

  m8c_issp_vecq_if #(.DEPTH(DEPTH), .VEC_SIZE(VS)) vq ();

  m8c_issp_vecq #(.DEPTH(DEPTH), .VEC_SIZE(VS)) dut (
    .osc   (osc),
    .rst_n (rst_n),
    .vq    (vq.slave)
  );

  always #5 osc = ~osc;

  logic [VS-1:0] mq [$];
  logic [VS-1:0] mstg;
  logic          movf;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("level", 32'(vq.level), 32'(mq.size()));
    chk("empty", 32'(vq.empty), 32'(mq.size() == 0));
    chk("full", 32'(vq.full), 32'(mq.size() == DEPTH));
    chk("vec_valid", 32'(vq.vec_valid), 32'(mq.size() != 0));
    chk("vec_data", 32'(vq.vec_data), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    chk("overflow", 32'(vq.overflow), 32'(movf));
  endtask

  // One clock: apply inputs, advance the model by the behavioural rules, check.
  task automatic step(input bit en, input logic [1:0] sel, input logic [7:0] data,
                      input bit rdy, input bit fl);
    bit pop;
    bit drop;
    vq.wr_en     = en;
    vq.wr_sel    = sel;
    vq.wr_data   = data;
    vq.vec_ready = rdy;
    vq.flush     = fl;
    @(posedge osc);
    pop  = (mq.size() > 0) && rdy;
    drop = 1'b0;
    if (fl) begin
      mq.delete();
      mstg = '0;
      movf = 1'b0;
    end else begin
      if (en && sel == 2'd0) mstg[7:0]   = data;
      if (en && sel == 2'd1) mstg[15:8]  = data;
      if (en && sel == 2'd2) mstg[21:16] = data[5:0];
      if (pop) void'(mq.pop_front());
      if (en && sel == 2'd3) begin
        if (mq.size() < DEPTH) mq.push_back(mstg);
        else drop = 1'b1;
      end
`ifdef M8C_ISSP_VECQ_STICKY_OVF_EN
      movf = movf | drop;
`else
      movf = drop;
`endif
    end
    #1;
    vq.wr_en     = 1'b0;
    vq.vec_ready = 1'b0;
    vq.flush     = 1'b0;
    check_all();
  endtask

  task automatic load_vec(input logic [VS-1:0] v);
    step(1'b1, 2'd0, v[7:0], 1'b0, 1'b0);
    step(1'b1, 2'd1, v[15:8], 1'b0, 1'b0);
    step(1'b1, 2'd2, {2'b00, v[21:16]}, 1'b0, 1'b0);
  endtask

  task automatic push(input bit rdy);
    step(1'b1, 2'd3, 8'h00, rdy, 1'b0);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 2'd0, 8'h00, rdy, 1'b0);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      load_vec(VS'($urandom));
      push(1'b0);
    end
  endtask

  initial begin
    logic [31:0] r;
    mstg = '0;
    movf = 1'b0;
    vq.wr_en = 1'b0; vq.wr_sel = 2'd0; vq.wr_data = 8'h00;
    vq.vec_ready = 1'b0; vq.flush = 1'b0;

    // Reset state
    #2;
    check_all();
    #5 rst_n = 1'b1;

    // Single vector assembled from lanes, then popped
    step(1'b1, 2'd0, 8'h12, 1'b0, 1'b0);
    step(1'b1, 2'd1, 8'h34, 1'b0, 1'b0);
    step(1'b1, 2'd2, 8'hEA, 1'b0, 1'b0);
    push(1'b0);
    chk("first_vec", 32'(vq.vec_data), 32'h002A3412);
    idle(1'b1);
    chk("first_pop_empty", 32'(vq.empty), 32'd1);

    // Fill to full, drop a ninth push, drain in order
    fill_random(DEPTH);
    chk("full_after_8", 32'(vq.full), 32'd1);
    push(1'b0);
    chk("overflow_on_drop", 32'(vq.overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) idle(1'b1);

    // Full FIFO: push with a same-cycle pop is accepted
    step(1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
    fill_random(DEPTH);
    load_vec(22'h155AA5);
    push(1'b1);
    chk("full_pushpop_ovf", 32'(vq.overflow), 32'd0);

    // Flush at level 5 coincident with a push; staging must be cleared
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("level5", 32'(vq.level), 32'd5);
    step(1'b1, 2'd3, 8'h00, 1'b0, 1'b1);
    push(1'b0);
    chk("staging_cleared", 32'(vq.vec_data), 32'd0);
    idle(1'b1);

    // Wrap-around: 20 pushes interleaved with pops at level 1..3
    load_vec(VS'($urandom));
    push(1'b0);
    for (int i = 0; i < 20; i++) begin
      r = $urandom;
      step(1'b1, 2'(r % 3), 8'(r >> 8), 1'b0, 1'b0);
      if (mq.size() >= 3)      push(1'b1);
      else if (mq.size() <= 1) push(1'b0);
      else                     push(1'($urandom % 2));
    end
    while (mq.size() > 0) idle(1'b1);

    // Overflow persistence over 100 idle cycles
    fill_random(DEPTH);
    push(1'b0);
    for (int i = 0; i < 100; i++) idle(1'b0);

    // Asynchronous reset in the middle of a drain
    idle(1'b1);
    idle(1'b1);
    #2 rst_n = 1'b0;
    #1;
    mq.delete();
    mstg = '0;
    movf = 1'b0;
    check_all();
    @(negedge osc);
    rst_n = 1'b1;
    push(1'b0);
    chk("post_reset_staging", 32'(vq.vec_data), 32'd0);
    load_vec(22'h3FFFFF);
    push(1'b1);
    idle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/m8c_issp_vecq.md
# m8c_issp_vecq

Vector queue feeding the M8C ISSP serial engine. It assembles 22-bit ISSP vectors from byte-wide host register writes and buffers them in a small synchronous FIFO. It presents them to the engine through a valid/ready handshake, so the host can post a burst of vectors without polling busy after each one. It sits between the host bus register decode (upstream, already synchronized to the oscillator domain) and the ISSP shift engine (downstream).

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..64
- VEC_SIZE, 22, ISSP vector width in bits
- osc  in  1  24 MHz oscillator clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  one-cycle write strobe from bus decode (osc domain)
- wr_sel  in  2  0=vector[7:0], 1=vector[15:8], 2=vector[21:16] (wr_data[5:0]), 3=push staging into FIFO
- wr_data  in  8  write data; ignored when wr_sel=3
- flush  in  1  one-cycle synchronous clear of FIFO, staging and flags
- vec_valid  out  1  head entry available
- vec_data  out  VEC_SIZE  head entry, MSB transmitted first by engine
- vec_ready  in  1  engine accepts head this cycle
- level  out  $clog2(DEPTH)+1  current occupancy 0..DEPTH
- full  out  1  level==DEPTH
- empty  out  1  level==0
- overflow  out  1  push rejected (see Configuration)

Reset is asynchronous and active-low on rst_n. Reset values: vec_valid=0, vec_data=0, level=0, full=0, empty=1, overflow=0, staging=0, pointers=0.

## Operation
- Staging register: lane writes (wr_sel 0..2) overwrite only their lane. Upper bits of wr_data are ignored for lane 2. Staging persists across pushes, so partial updates between vectors are legal.
- Push (wr_en && wr_sel==3): enqueues staging at wr_ptr when not full, or when full and a pop occurs in the same cycle. Otherwise the push is dropped and overflow is raised.
- Pop (vec_valid && vec_ready): rd_ptr advances and level decrements. vec_ready while empty is ignored.
- Simultaneous push and pop: level is unchanged and both pointers advance. When level==1, the pushed entry becomes the new head next cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. level is the authoritative full/empty source.
- vec_valid = !empty. vec_data = mem[rd_ptr], first-word-fall-through. It is 0 when empty.
- flush: highest priority. It overrides a same-cycle push, pop or lane write. Pointers, level, staging and overflow go to 0.
- A lane write and a push cannot coincide, because there is a single wr_sel.

## Timing
- Push at cycle N: level, empty and vec_valid update at N+1. vec_data is valid at N+1.
- Pop at cycle N: the next head or empty is visible at N+1.
- Lane write at N: staging is updated at N+1. A push at N+1 captures the new value.
- Back-to-back pushes every cycle are accepted until full. Sustained push+pop with level≥1 achieves 1 vector per cycle.
- Reset asserted mid-burst: the FIFO is cleared immediately (asynchronous). The engine must see vec_valid=0 and abandon any vector not yet popped.

## Configuration
- M8C_ISSP_VECQ_STICKY_OVF_EN
  - Defined: overflow is sticky. It is set by a dropped push and cleared only by flush or reset.
  - Undefined: overflow is a one-cycle pulse in the cycle after each dropped push.

## Structure
- Package m8c_issp_pkg holds:
  - ISSP_VEC_SIZE=22
  - wr_sel encodings VECQ_SEL_LO/MED/HI/PUSH
  - the vector typedef, shared with the shift engine
- Sub-module m8c_issp_vec_fifo: generic synchronous FWFT FIFO with data, level, full and empty, and with a flush input.
- The top level holds the staging register, push/overflow logic and the configuration macro.

## Test plan
- Write lanes 0x12, 0x34, 0x2A, then push → next cycle vec_valid=1, vec_data=22'h2A3412, level=1. Pulse vec_ready → empty=1, vec_data=0.
- Push 8 distinct vectors with ready=0 → full=1, level=8. A 9th push is dropped and overflow=1. Drain them → all 8 are output in order with no loss.
- Full FIFO, push and vec_ready in the same cycle → push accepted, level stays 8, overflow stays 0.
- Wrap-around: 20 push/pop pairs interleaved at level 1..3 → outputs match the input sequence exactly.
- flush coincident with a push at level 5 → next cycle level=0, empty=1, overflow=0, staging=0.
- Overflow persistence: overflow stays 1 for 100 cycles with the macro defined, and is 1 for exactly one cycle without it. Assert rst_n low mid-drain → outputs return to reset values without waiting for a clock edge.
